// File: rtl/trail_fb_arbiter.sv
// Framebuffer write-port arbiter: blue/red trail writers served round-robin with
// locked bursts, plus an internal screen-clear engine that takes priority.
module trail_fb_arbiter #(
   parameter int unsigned ADDR_W      = 20,
   parameter int unsigned DATA_W      = 16,
   parameter int unsigned CLEAR_WORDS = 153600,
   parameter int unsigned BURST_MAX   = 16
) (
   input  logic              Clk,
   input  logic              Reset_n,
   input  logic              clear_start,
   input  logic              fb_free,
   input  logic              b_valid,
   input  logic [ADDR_W-1:0] b_addr,
   input  logic [DATA_W-1:0] b_data,
   input  logic              b_last,
   output logic              b_ready,
   input  logic              r_valid,
   input  logic [ADDR_W-1:0] r_addr,
   input  logic [DATA_W-1:0] r_data,
   input  logic              r_last,
   output logic              r_ready,
   output logic              fb_we,
   output logic [ADDR_W-1:0] fb_addr,
   output logic [DATA_W-1:0] fb_data,
   output logic              clear_busy,
   output logic              clear_done,
   output logic              overrun
);

   typedef enum logic [1:0] {
      IDLE,
      CLEAR,
      GNT_B,
      GNT_R
   } state_t;

   localparam logic [4:0]        BURST_LAST = 5'(BURST_MAX - 1);
   localparam logic [ADDR_W-1:0] CLR_LAST   = ADDR_W'(CLEAR_WORDS - 1);

   state_t            state;
   logic              rr;
   logic              clr_pend;
   logic [4:0]        burst_cnt;
   logic [ADDR_W-1:0] clr_addr;
   logic              burst_full;

   always_comb begin
      b_ready = 1'b0;
      r_ready = 1'b0;
      if (Reset_n) begin
         b_ready = (state == GNT_B) && b_valid && fb_free;
         r_ready = (state == GNT_R) && r_valid && fb_free;
      end
   end

   assign burst_full = (burst_cnt == BURST_LAST);
   assign clear_busy = clr_pend | (state == CLEAR);

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state      <= IDLE;
         rr         <= 1'b0;
         clr_pend   <= 1'b0;
         burst_cnt  <= '0;
         clr_addr   <= '0;
         fb_we      <= 1'b0;
         fb_addr    <= '0;
         fb_data    <= '0;
         clear_done <= 1'b0;
         overrun    <= 1'b0;
      end else begin
         fb_we      <= 1'b0;
         clear_done <= 1'b0;
         overrun    <= 1'b0;

         if (clear_start && (state != CLEAR))
            clr_pend <= 1'b1;

         case (state)
            IDLE: begin
               // a clear_start seen in IDLE wins over a same-cycle player request
               if (clr_pend || clear_start) begin
                  state    <= CLEAR;
                  clr_pend <= 1'b0;
                  clr_addr <= '0;
               end else if (b_valid && (!r_valid || !rr)) begin
                  state     <= GNT_B;
                  burst_cnt <= '0;
               end else if (r_valid) begin
                  state     <= GNT_R;
                  burst_cnt <= '0;
               end
            end

            CLEAR: begin
               if (fb_free) begin
                  fb_we   <= 1'b1;
                  fb_addr <= clr_addr;
                  fb_data <= '0;
                  if (clr_addr == CLR_LAST) begin
                     clear_done <= 1'b1;
                     state      <= IDLE;
                  end else begin
                     clr_addr <= clr_addr + ADDR_W'(1);
                  end
               end
            end

            GNT_B: begin
               if (b_ready) begin
                  fb_we     <= 1'b1;
                  fb_addr   <= b_addr;
                  fb_data   <= b_data;
                  burst_cnt <= burst_cnt + 5'd1;
                  if (b_last) begin
                     state <= IDLE;
                     rr    <= 1'b1;
                  end else if (burst_full) begin
                     overrun <= 1'b1;
                     state   <= IDLE;
                     rr      <= ~rr;
                  end
               end
            end

            GNT_R: begin
               if (r_ready) begin
                  fb_we     <= 1'b1;
                  fb_addr   <= r_addr;
                  fb_data   <= r_data;
                  burst_cnt <= burst_cnt + 5'd1;
                  if (r_last) begin
                     state <= IDLE;
                     rr    <= 1'b0;
                  end else if (burst_full) begin
                     overrun <= 1'b1;
                     state   <= IDLE;
                     rr      <= ~rr;
                  end
               end
            end

            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_trail_fb_arbiter.sv
// Self-checking bench for trail_fb_arbiter: a write-stream scoreboard predicted
// from the arbitration rules, plus directed latency/stall/reset checks.
module tb_trail_fb_arbiter;

   logic        Clk, Reset_n, clear_start, fb_free;
   logic        b_valid, b_last, b_ready, r_valid, r_last, r_ready;
   logic [19:0] b_addr, r_addr, fb_addr;
   logic [15:0] b_data, r_data, fb_data;
   logic        fb_we, clear_busy, clear_done, overrun;

   trail_fb_arbiter #(
      .ADDR_W(20), .DATA_W(16), .CLEAR_WORDS(8), .BURST_MAX(16)
   ) dut (
      .Clk(Clk), .Reset_n(Reset_n), .clear_start(clear_start), .fb_free(fb_free),
      .b_valid(b_valid), .b_addr(b_addr), .b_data(b_data), .b_last(b_last), .b_ready(b_ready),
      .r_valid(r_valid), .r_addr(r_addr), .r_data(r_data), .r_last(r_last), .r_ready(r_ready),
      .fb_we(fb_we), .fb_addr(fb_addr), .fb_data(fb_data),
      .clear_busy(clear_busy), .clear_done(clear_done), .overrun(overrun)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   typedef struct {
      logic [19:0] a;
      logic [15:0] d;
      bit          done;
      bit          ovr;
   } exp_t;

   exp_t exp_q[$];
   int   n_cmp  = 0;
   int   n_fail = 0;
   bit   m_rr   = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Model of one player burst: words go out in order, a burst reaching
   // BURST_MAX words without last is cut off and flips the pointer.
   task automatic model_burst(input bit red, input logic [19:0] a0,
                              input logic [15:0] dq[$], input bit final_last);
      exp_t e;
      for (int i = 0; i < dq.size(); i++) begin
         e.a    = a0 + 20'(i);
         e.d    = dq[i];
         e.done = 1'b0;
         e.ovr  = 1'b0;
         if (final_last && (i == dq.size() - 1)) begin
            exp_q.push_back(e);
            m_rr = red ? 1'b0 : 1'b1;
            return;
         end
         if (i == 15) begin
            e.ovr = 1'b1;
            exp_q.push_back(e);
            m_rr = ~m_rr;
            return;
         end
         exp_q.push_back(e);
      end
   endtask

   task automatic model_clear(input int n, input bit complete);
      exp_t e;
      for (int i = 0; i < n; i++) begin
         e.a    = 20'(i);
         e.d    = 16'h0000;
         e.done = complete && (i == 7);
         e.ovr  = 1'b0;
         exp_q.push_back(e);
      end
   endtask

   exp_t cmp_e;
   bit   cmp_d, cmp_o;
   always @(negedge Clk) begin
      cmp_d = 1'b0;
      cmp_o = 1'b0;
      if (fb_we) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_write_addr", fb_addr, 20'hFFFFF);
         end else begin
            cmp_e = exp_q.pop_front();
            chk("sb_addr", fb_addr, cmp_e.a);
            chk("sb_data", fb_data, cmp_e.d);
            cmp_d = cmp_e.done;
            cmp_o = cmp_e.ovr;
         end
      end
      chk("sb_clear_done", clear_done, cmp_d);
      chk("sb_overrun", overrun, cmp_o);
      chk("ready_exclusive", b_ready && r_ready, 0);
      chk("b_ready_legal", b_ready && !(b_valid && fb_free), 0);
      chk("r_ready_legal", r_ready && !(r_valid && fb_free), 0);
   end

   task automatic drive(input bit red, input bit v, input logic [19:0] a,
                        input logic [15:0] d, input bit l);
      if (red) begin
         r_valid = v; r_addr = a; r_data = d; r_last = l;
      end else begin
         b_valid = v; b_addr = a; b_data = d; b_last = l;
      end
   endtask

   task automatic send_burst(input bit red, input logic [19:0] a0,
                             input logic [15:0] dq[$], input bit final_last);
      logic [19:0] a;
      bit          ok;
      for (int i = 0; i < dq.size(); i++) begin
         a  = a0 + 20'(i);
         ok = 1'b0;
         drive(red, 1'b1, a, dq[i], final_last && (i == dq.size() - 1));
         for (int t = 0; t < 300 && !ok; t++) begin
            @(negedge Clk);
            if (red ? r_ready : b_ready) ok = 1'b1;
         end
         chk(red ? "r_accept_timeout" : "b_accept_timeout", ok, 1);
         if (!ok) break;
         @(posedge Clk); #1;
         chk("lat_we", fb_we, 1);
         chk("lat_addr", fb_addr, a);
         chk("lat_data", fb_data, dq[i]);
      end
      drive(red, 1'b0, '0, '0, 1'b0);
   endtask

   task automatic drain();
      for (int t = 0; t < 300 && exp_q.size() != 0; t++) @(negedge Clk);
      repeat (3) @(negedge Clk);
      chk("queue_drained", exp_q.size(), 0);
      chk("idle_we", fb_we, 0);
      @(posedge Clk); #1;
   endtask

   task automatic do_reset();
      @(posedge Clk); #1;
      Reset_n = 1'b0;
      m_rr    = 1'b0;
      repeat (2) @(posedge Clk);
      #1 Reset_n = 1'b1;
   endtask

   logic [15:0] dq_a[$], dq_b[$], dq_r20[$], dq_r16[$], dq_r4[$];
   bit          sched [8] = '{1, 0, 0, 1, 1, 1, 1, 1};
   bit          seen;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      Reset_n = 1'b0; clear_start = 1'b0; fb_free = 1'b1;
      drive(1'b0, 1'b1, 20'h12345, 16'hABCD, 1'b1);
      drive(1'b1, 1'b1, 20'h54321, 16'hDCBA, 1'b1);
      #3;
      chk("rst_fb_we", fb_we, 0);
      chk("rst_fb_addr", fb_addr, 0);
      chk("rst_fb_data", fb_data, 0);
      chk("rst_clear_busy", clear_busy, 0);
      chk("rst_b_ready", b_ready, 0);
      chk("rst_r_ready", r_ready, 0);
      drive(1'b0, 1'b0, '0, '0, 1'b0);
      drive(1'b1, 1'b0, '0, '0, 1'b0);
      @(posedge Clk); #1 Reset_n = 1'b1;

      // blue alone, literal expectations at 0x00100
      dq_a = '{16'h000F, 16'h00F0, 16'h0F00};
      model_burst(1'b0, 20'h00100, dq_a, 1'b1);
      send_burst(1'b0, 20'h00100, dq_a, 1'b1);
      drain();

      // both valid after reset, twice; then force rr=1 and contend again
      do_reset();
      dq_a = '{16'h1111, 16'h2222};
      dq_b = '{16'h3333, 16'h4444, 16'h5555};
      for (int rep = 0; rep < 3; rep++) begin
         if (rep == 2) begin
            model_burst(1'b0, 20'h00700, '{16'h7777}, 1'b1);
            send_burst(1'b0, 20'h00700, '{16'h7777}, 1'b1);
            drain();
         end
         if (m_rr) begin
            model_burst(1'b1, 20'h00300, dq_b, 1'b1);
            model_burst(1'b0, 20'h00200, dq_a, 1'b1);
         end else begin
            model_burst(1'b0, 20'h00200, dq_a, 1'b1);
            model_burst(1'b1, 20'h00300, dq_b, 1'b1);
         end
         fork
            send_burst(1'b0, 20'h00200, dq_a, 1'b1);
            send_burst(1'b1, 20'h00300, dq_b, 1'b1);
         join
         drain();
      end

      // red 4 words with fb_free stalling
      dq_b = '{16'hA001, 16'hA002, 16'hA003, 16'hA004};
      model_burst(1'b1, 20'h00800, dq_b, 1'b1);
      fork
         send_burst(1'b1, 20'h00800, dq_b, 1'b1);
         begin
            @(posedge Clk); #1;
            for (int i = 0; i < 8; i++) begin
               fb_free = sched[i];
               @(negedge Clk);
               chk("r_ready_tracks_free", r_ready, fb_free && r_valid);
               @(posedge Clk); #1;
            end
            fb_free = 1'b1;
         end
      join
      drain();

      // clear requested mid blue burst
      dq_a = '{16'h0001, 16'h0002, 16'h0003, 16'h0004};
      model_burst(1'b0, 20'h00400, dq_a, 1'b1);
      model_clear(8, 1'b1);
      fork
         send_burst(1'b0, 20'h00400, dq_a, 1'b1);
         begin
            repeat (2) @(posedge Clk);
            #1 clear_start = 1'b1;
            @(posedge Clk);
            #1 clear_start = 1'b0;
            seen = 1'b0;
            for (int t = 0; t < 100 && !seen; t++) begin
               @(negedge Clk);
               if (clear_done) begin
                  seen = 1'b1;
                  chk("busy_at_done", clear_busy, 0);
               end else begin
                  chk("busy_while_clear", clear_busy, 1);
               end
            end
            chk("clear_done_seen", seen, 1);
         end
      join
      drain();

      // red overrun with blue waiting (rr is 1 here, so the flip hands over to blue)
      dq_r20.delete(); dq_r16.delete(); dq_r4.delete();
      for (int i = 0; i < 20; i++) dq_r20.push_back(16'hB000 + 16'(i));
      for (int i = 0; i < 16; i++) dq_r16.push_back(dq_r20[i]);
      for (int i = 16; i < 20; i++) dq_r4.push_back(dq_r20[i]);
      dq_a = '{16'hC001, 16'hC002};
      chk("model_rr_before_overrun", m_rr, 1);
      model_burst(1'b1, 20'h00500, dq_r16, 1'b0);
      model_burst(1'b0, 20'h00600, dq_a, 1'b1);
      model_burst(1'b1, 20'h00510, dq_r4, 1'b0);
      fork
         send_burst(1'b1, 20'h00500, dq_r20, 1'b0);
         begin
            repeat (5) @(posedge Clk);
            #1 send_burst(1'b0, 20'h00600, dq_a, 1'b1);
         end
      join
      drain();

      // reset dropped while the 5th clear word is on the port
      do_reset();
      @(posedge Clk); #1 clear_start = 1'b1;
      model_clear(5, 1'b0);
      @(posedge Clk); #1 clear_start = 1'b0;
      seen = 1'b0;
      for (int t = 0; t < 50 && !seen; t++) begin
         @(negedge Clk);
         if (fb_we && fb_addr == 20'h4) seen = 1'b1;
      end
      chk("clear_word5_seen", seen, 1);
      #1 Reset_n = 1'b0;
      #1;
      chk("mid_rst_fb_we", fb_we, 0);
      chk("mid_rst_fb_addr", fb_addr, 0);
      chk("mid_rst_fb_data", fb_data, 0);
      chk("mid_rst_clear_busy", clear_busy, 0);
      chk("mid_rst_clear_done", clear_done, 0);
      chk("mid_rst_overrun", overrun, 0);
      repeat (2) @(posedge Clk);
      #1 Reset_n = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge Clk);
         chk("post_rst_busy", clear_busy, 0);
         chk("post_rst_we", fb_we, 0);
      end
      chk("queue_after_reset", exp_q.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
